// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data memory: core (0) and loader (1).
// Combinational grant and memory drive; registered read data, rvalid and range error.
module dmem_arbiter #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned MAX_LOCK = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [63:0] core_adr_i,
    input  logic [63:0] core_wdata_i,
    output logic        core_gnt_o,
    output logic        core_stall_o,
    output logic        core_rvalid_o,
    output logic [63:0] core_rdata_o,
    input  logic        ldr_req_i,
    input  logic        ldr_we_i,
    input  logic [63:0] ldr_adr_i,
    input  logic [63:0] ldr_wdata_i,
    input  logic        ldr_lock_i,
    output logic        ldr_gnt_o,
    output logic        ldr_stall_o,
    output logic        ldr_rvalid_o,
    output logic [63:0] ldr_rdata_o,
    output logic        err_o,
    output logic [63:0] mem_adr_o,
    output logic [63:0] mem_datain_o,
    output logic        mem_w_o,
    output logic        mem_r_o,
    input  logic [63:0] mem_dataout_i
);

    localparam int unsigned CntW = $clog2(MAX_LOCK + 1);

    // last_q: 0 = core granted last, 1 = loader granted last
    logic            last_q, last_d;
    logic            locked_q, locked_d;
    logic            fair_q, fair_d;
    logic [CntW-1:0] lock_cnt_q, lock_cnt_d;
    logic            core_rvalid_q, ldr_rvalid_q, err_q;
    logic [63:0]     core_rdata_q, ldr_rdata_q;

    logic            gnt_core, gnt_ldr, gnt_any;
    logic            sel_we, in_range;
    logic [63:0]     sel_adr, sel_wdata, rd_val;

    always_comb begin
        gnt_core = 1'b0;
        gnt_ldr  = 1'b0;
        if (locked_q && ldr_req_i && !fair_q) begin
            gnt_ldr = 1'b1;
        end else if (core_req_i && ldr_req_i) begin
            if (fair_q || last_q) gnt_core = 1'b1;
            else                  gnt_ldr  = 1'b1;
        end else if (core_req_i) begin
            gnt_core = 1'b1;
        end else if (ldr_req_i) begin
            gnt_ldr = 1'b1;
        end
    end

    assign gnt_any   = gnt_core | gnt_ldr;
    assign sel_we    = gnt_ldr ? ldr_we_i    : core_we_i;
    assign sel_adr   = gnt_ldr ? ldr_adr_i   : core_adr_i;
    assign sel_wdata = gnt_ldr ? ldr_wdata_i : core_wdata_i;
    assign in_range  = sel_adr < 64'(DEPTH);
    assign rd_val    = in_range ? mem_dataout_i : 64'd0;

    assign mem_adr_o    = gnt_any ? sel_adr   : 64'd0;
    assign mem_datain_o = gnt_any ? sel_wdata : 64'd0;
    assign mem_r_o      = gnt_any & ~sel_we;
    assign mem_w_o      = gnt_any & sel_we & in_range;

    assign core_gnt_o   = gnt_core;
    assign ldr_gnt_o    = gnt_ldr;
    assign core_stall_o = core_req_i & ~gnt_core;
    assign ldr_stall_o  = ldr_req_i & ~gnt_ldr;

    always_comb begin
        last_d     = gnt_any ? gnt_ldr : last_q;
        locked_d   = locked_q;
        lock_cnt_d = lock_cnt_q;
        fair_d     = gnt_any ? 1'b0 : fair_q;
        if (!ldr_req_i || !ldr_lock_i) begin
            locked_d   = 1'b0;
            lock_cnt_d = '0;
        end else if (gnt_ldr) begin
            // Forced release hands the next contested cycle to the core
            if (lock_cnt_q + 1'b1 == CntW'(MAX_LOCK)) begin
                locked_d   = 1'b0;
                lock_cnt_d = '0;
                fair_d     = 1'b1;
            end else begin
                locked_d   = 1'b1;
                lock_cnt_d = lock_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q        <= 1'b1;
            locked_q      <= 1'b0;
            lock_cnt_q    <= '0;
            fair_q        <= 1'b0;
            core_rvalid_q <= 1'b0;
            ldr_rvalid_q  <= 1'b0;
            core_rdata_q  <= 64'd0;
            ldr_rdata_q   <= 64'd0;
            err_q         <= 1'b0;
        end else begin
            last_q        <= last_d;
            locked_q      <= locked_d;
            lock_cnt_q    <= lock_cnt_d;
            fair_q        <= fair_d;
            core_rvalid_q <= gnt_core & ~sel_we;
            ldr_rvalid_q  <= gnt_ldr & ~sel_we;
            err_q         <= gnt_any & ~in_range;
            if (gnt_core && !sel_we) core_rdata_q <= rd_val;
            if (gnt_ldr && !sel_we)  ldr_rdata_q  <= rd_val;
        end
    end

    assign core_rvalid_o = core_rvalid_q;
    assign ldr_rvalid_o  = ldr_rvalid_q;
    assign core_rdata_o  = core_rdata_q;
    assign ldr_rdata_o   = ldr_rdata_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with an 8-word behavioural memory attached.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req, core_we, core_gnt, core_stall, core_rvalid;
    logic [63:0] core_adr, core_wdata, core_rdata;
    logic        ldr_req, ldr_we, ldr_lock, ldr_gnt, ldr_stall, ldr_rvalid;
    logic [63:0] ldr_adr, ldr_wdata, ldr_rdata;
    logic        err, mem_w, mem_r;
    logic [63:0] mem_adr, mem_datain, mem_dataout;

    logic [63:0] mem [8];
    logic        pre_en;
    logic [2:0]  pre_adr;
    logic [63:0] pre_val;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_en)     mem[pre_adr] <= pre_val;
        else if (mem_w) mem[mem_adr[2:0]] <= mem_datain;
    end

    assign mem_dataout = (mem_r && mem_adr < 64'd8) ? mem[mem_adr[2:0]] : 64'd0;

    dmem_arbiter #(.DEPTH(8), .MAX_LOCK(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .core_req_i   (core_req),
        .core_we_i    (core_we),
        .core_adr_i   (core_adr),
        .core_wdata_i (core_wdata),
        .core_gnt_o   (core_gnt),
        .core_stall_o (core_stall),
        .core_rvalid_o(core_rvalid),
        .core_rdata_o (core_rdata),
        .ldr_req_i    (ldr_req),
        .ldr_we_i     (ldr_we),
        .ldr_adr_i    (ldr_adr),
        .ldr_wdata_i  (ldr_wdata),
        .ldr_lock_i   (ldr_lock),
        .ldr_gnt_o    (ldr_gnt),
        .ldr_stall_o  (ldr_stall),
        .ldr_rvalid_o (ldr_rvalid),
        .ldr_rdata_o  (ldr_rdata),
        .err_o        (err),
        .mem_adr_o    (mem_adr),
        .mem_datain_o (mem_datain),
        .mem_w_o      (mem_w),
        .mem_r_o      (mem_r),
        .mem_dataout_i(mem_dataout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(input logic req, input logic we, input logic [63:0] adr,
                            input logic [63:0] wd);
        core_req = req; core_we = we; core_adr = adr; core_wdata = wd;
    endtask

    task automatic set_ldr(input logic req, input logic we, input logic lock,
                           input logic [63:0] adr, input logic [63:0] wd);
        ldr_req = req; ldr_we = we; ldr_lock = lock; ldr_adr = adr; ldr_wdata = wd;
    endtask

    task automatic preset(input logic [2:0] a, input logic [63:0] v);
        pre_en = 1'b1; pre_adr = a; pre_val = v;
        tick();
        pre_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pre_en = 1'b0; pre_adr = '0; pre_val = '0;
        set_core(1'b0, 1'b0, 64'd0, 64'd0);
        set_ldr(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        tick();
        preset(3'd0, 64'd15);
        preset(3'd1, 64'h11);
        preset(3'd2, 64'h22);
        checks++;
        if ({core_rvalid, ldr_rvalid, err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got %b want 000", {core_rvalid, ldr_rvalid, err});
        end
        checks++;
        if (core_rdata !== 64'd0 || ldr_rdata !== 64'd0) begin
            errors++;
            $display("FAIL reset_rdata got %h/%h want 0/0", core_rdata, ldr_rdata);
        end
        checks++;
        if ({core_gnt, ldr_gnt, mem_w, mem_r} !== 4'b0000 || mem_adr !== 64'd0) begin
            errors++;
            $display("FAIL reset_idle got %b adr %h want 0000 adr 0",
                     {core_gnt, ldr_gnt, mem_w, mem_r}, mem_adr);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        logic exp_core;
        set_core(1'b1, 1'b0, 64'd1, 64'd0);
        set_ldr(1'b1, 1'b0, 1'b0, 64'd2, 64'd0);
        for (int i = 0; i < 4; i++) begin
            exp_core = (i % 2 == 0);
            #1;
            checks++;
            if (core_gnt !== exp_core || ldr_gnt !== !exp_core) begin
                errors++;
                $display("FAIL rr_gnt cycle %0d got core %b ldr %b want core %b",
                         i + 1, core_gnt, ldr_gnt, exp_core);
            end
            checks++;
            if (core_stall !== !exp_core) begin
                errors++;
                $display("FAIL rr_stall cycle %0d got %b want %b", i + 1, core_stall,
                         !exp_core);
            end
            tick();
            if (i == 0) begin
                checks++;
                if (core_rvalid !== 1'b1 || ldr_rvalid !== 1'b0 || core_rdata !== 64'h11) begin
                    errors++;
                    $display("FAIL rr_rdata got v %b/%b d %h want 1/0 d 11",
                             core_rvalid, ldr_rvalid, core_rdata);
                end
            end
        end
        set_core(1'b0, 1'b0, 64'd0, 64'd0);
        set_ldr(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        tick();
        checks++;
        if (ldr_rdata !== 64'h22) begin
            errors++;
            $display("FAIL rr_ldr_rdata got %h want 22", ldr_rdata);
        end
    endtask

    task automatic test_core_read();
        set_core(1'b1, 1'b0, 64'd0, 64'd0);
        #1;
        checks++;
        if (core_gnt !== 1'b1 || core_stall !== 1'b0 || mem_r !== 1'b1) begin
            errors++;
            $display("FAIL core_read_gnt got gnt %b stall %b r %b want 1 0 1",
                     core_gnt, core_stall, mem_r);
        end
        tick();
        set_core(1'b0, 1'b0, 64'd0, 64'd0);
        checks++;
        if (core_rvalid !== 1'b1 || core_rdata !== 64'd15 || ldr_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL core_read_data got v %b d %0d lv %b want 1 15 0",
                     core_rvalid, core_rdata, ldr_rvalid);
        end
        tick();
        checks++;
        if (core_rvalid !== 1'b0 || core_rdata !== 64'd15) begin
            errors++;
            $display("FAIL core_read_pulse got v %b d %0d want 0 15", core_rvalid, core_rdata);
        end
    endtask

    task automatic test_write_then_read();
        set_ldr(1'b1, 1'b1, 1'b0, 64'd5, 64'hAB);
        #1;
        checks++;
        if (ldr_gnt !== 1'b1 || mem_w !== 1'b1 || mem_r !== 1'b0 || mem_datain !== 64'hAB) begin
            errors++;
            $display("FAIL ldr_write got gnt %b w %b r %b d %h want 1 1 0 ab",
                     ldr_gnt, mem_w, mem_r, mem_datain);
        end
        tick();
        set_ldr(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        set_core(1'b1, 1'b0, 64'd5, 64'd0);
        checks++;
        if (ldr_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL ldr_write_rvalid got %b want 0", ldr_rvalid);
        end
        tick();
        set_core(1'b0, 1'b0, 64'd0, 64'd0);
        checks++;
        if (core_rvalid !== 1'b1 || core_rdata !== 64'hAB) begin
            errors++;
            $display("FAIL wr_rd got v %b d %h want 1 ab", core_rvalid, core_rdata);
        end
    endtask

    task automatic test_lock();
        logic [7:0] exp_ldr;
        exp_ldr = 8'b1110_1111;  // bit i = cycle i+1, loader grant expected
        set_core(1'b1, 1'b0, 64'd4, 64'd0);
        set_ldr(1'b1, 1'b1, 1'b1, 64'd3, 64'h33);
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if (ldr_gnt !== exp_ldr[i] || core_gnt !== !exp_ldr[i]) begin
                errors++;
                $display("FAIL lock_gnt cycle %0d got ldr %b core %b want ldr %b",
                         i + 1, ldr_gnt, core_gnt, exp_ldr[i]);
            end
            tick();
        end
        set_core(1'b0, 1'b0, 64'd0, 64'd0);
        set_ldr(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        tick();
        checks++;
        if (mem[3] !== 64'h33) begin
            errors++;
            $display("FAIL lock_write got %h want 33", mem[3]);
        end
    endtask

    task automatic test_out_of_range();
        set_core(1'b1, 1'b1, 64'd9, 64'hDEAD);
        #1;
        checks++;
        if (core_gnt !== 1'b1 || mem_w !== 1'b0) begin
            errors++;
            $display("FAIL oob_write got gnt %b w %b want 1 0", core_gnt, mem_w);
        end
        tick();
        set_core(1'b0, 1'b0, 64'd0, 64'd0);
        checks++;
        if (err !== 1'b1 || core_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL oob_write_err got err %b v %b want 1 0", err, core_rvalid);
        end
        tick();
        checks++;
        if (err !== 1'b0 || mem[1] !== 64'h11) begin
            errors++;
            $display("FAIL oob_write_after got err %b mem1 %h want 0 11", err, mem[1]);
        end
        set_core(1'b1, 1'b0, 64'd9, 64'd0);
        tick();
        set_core(1'b0, 1'b0, 64'd0, 64'd0);
        checks++;
        if (core_rvalid !== 1'b1 || core_rdata !== 64'd0 || err !== 1'b1) begin
            errors++;
            $display("FAIL oob_read got v %b d %h err %b want 1 0 1",
                     core_rvalid, core_rdata, err);
        end
        tick();
    endtask

    task automatic test_reset_mid_lock();
        // Core was granted last, so the loader wins the first tie and locks
        set_core(1'b1, 1'b0, 64'd2, 64'd0);
        set_ldr(1'b1, 1'b0, 1'b1, 64'd0, 64'd0);
        tick();
        set_ldr(1'b1, 1'b0, 1'b1, 64'd12, 64'd0);
        rst = 1'b1;
        #1;
        checks++;
        if (ldr_gnt !== 1'b1 || ldr_rvalid !== 1'b1) begin
            errors++;
            $display("FAIL mid_lock_pre got gnt %b v %b want 1 1", ldr_gnt, ldr_rvalid);
        end
        tick();
        rst = 1'b0;
        set_ldr(1'b1, 1'b0, 1'b0, 64'd1, 64'd0);
        checks++;
        if (ldr_rvalid !== 1'b0 || err !== 1'b0 || ldr_rdata !== 64'd0) begin
            errors++;
            $display("FAIL mid_lock_rst got v %b err %b d %h want 0 0 0",
                     ldr_rvalid, err, ldr_rdata);
        end
        #1;
        checks++;
        if (core_gnt !== 1'b1 || ldr_gnt !== 1'b0) begin
            errors++;
            $display("FAIL post_rst_tie got core %b ldr %b want 1 0", core_gnt, ldr_gnt);
        end
        tick();
        set_core(1'b0, 1'b0, 64'd0, 64'd0);
        set_ldr(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        tick();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_core_read();
        test_write_then_read();
        test_lock();
        test_out_of_range();
        test_reset_mid_lock();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and sequencer for the single-port 64-bit data memory. It sits between the pipeline MEM stage (requester 0, "core") and the memory-image loader/debug port (requester 1, "ldr"). It grants at most one access per cycle and drives the memory's address, data and read/write strobes. It registers read data, flags out-of-range addresses and produces the core stall signal.

## Interface
- DEPTH, 8: number of 64-bit words in the attached memory; legal addresses are 0..DEPTH-1.
- MAX_LOCK, 4: maximum number of consecutive locked loader grants before a forced release.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- core_req  in  1  core access request.
- core_we  in  1  1 = write, 0 = read.
- core_adr  in  64  core word address.
- core_wdata  in  64  core write data.
- core_gnt  out  1  core access performed this cycle (combinational).
- core_stall  out  1  core_req & ~core_gnt (combinational).
- core_rvalid  out  1  registered; core read data valid.
- core_rdata  out  64  registered read data.
- ldr_req, ldr_we, ldr_adr, ldr_wdata, ldr_gnt, ldr_rvalid, ldr_rdata: same as the core_* signals, for the loader.
- ldr_lock  in  1  loader requests that its grant be held across consecutive cycles.
- err  out  1  registered; the previous granted access was out of range.
- mem_adr  out  64  memory address.
- mem_datain  out  64  memory write data.
- mem_w  out  1  memory write strobe.
- mem_r  out  1  memory read strobe.
- mem_dataout  in  64  memory read data (combinational from mem_adr when mem_r is high).

## Operation
- Grant computation is combinational. Exactly one requester or none is granted each cycle.
- State: `last` (1 bit, last granted requester), `locked` (1 bit), `lock_cnt` (0..MAX_LOCK), `fair` (1 bit, forced-release flag).
- Arbitration order:
  - If `locked` and ldr_req and not `fair`, the loader is granted.
  - Otherwise, if only one requester is active, that requester is granted.
  - If both are active, the requester that is not `last` is granted (round-robin).
  - If `fair` is set and both are active, the core is granted.
- Granted access drives mem_adr, mem_datain and mem_r = ~we.
- mem_w = we only when the address is in range (adr < DEPTH). An out-of-range write is dropped.
- When nothing is granted: mem_w = 0, mem_r = 0, mem_adr = 0, mem_datain = 0.
- Granted read: on the next edge, rdata ← mem_dataout (or 0 if out of range) and rvalid ← 1 for that requester only. rvalid is a 1-cycle pulse. rdata holds its value until the next read by the same requester.
- Granted write: rvalid is not asserted.
- err ← 1 for one cycle after any out-of-range granted access, read or write. err ← 0 otherwise.
- Lock handling:
  - A loader grant with ldr_lock = 1 sets `locked` and increments lock_cnt.
  - When lock_cnt reaches MAX_LOCK: `locked` ← 0, lock_cnt ← 0, `fair` ← 1.
  - `fair` clears after the next cycle in which any grant occurs.
  - ldr_lock = 0 or ldr_req = 0 clears `locked` and lock_cnt immediately on that edge.
- `last` updates to the granted requester whenever a grant occurs; otherwise it holds.

## Timing
- Reset values: last = 1 (core wins the first tie), locked = 0, lock_cnt = 0, fair = 0, all rvalid = 0, all rdata = 0, err = 0.
- Grant, stall and mem_* outputs are combinational and follow the current inputs in the same cycle.
- Write latency: the memory updates at the edge ending the grant cycle.
- Read latency: 1 cycle from the grant cycle to rvalid/rdata.
- Requesters hold req/adr/we/wdata stable while stalled. The arbiter keeps no queue.
- Reset asserted mid-lock: all state returns to reset values on that edge. rvalid for an in-flight read is suppressed (rvalid = 0).
- Simultaneous read and write to the same address by the two requesters: only the granted one occurs. The other sees the memory after the first completes.
- Worst-case core wait: MAX_LOCK cycles while the loader holds a lock; otherwise 1 cycle.

## Test plan
- Reset, then core read of adr 0 with memory preset to 15 → core_gnt = 1, no stall; next cycle core_rvalid = 1 and core_rdata = 15; ldr_rvalid = 0.
- Both requesters active every cycle, no lock, for 4 cycles → grants alternate core, ldr, core, ldr; core_stall = 1 exactly in cycles 2 and 4.
- Loader write 0xAB to adr 5, then core read of adr 5 → core_rdata = 0xAB one cycle after the core grant.
- Loader with ldr_lock = 1 plus core_req held high for 8 cycles (MAX_LOCK = 4) → 4 consecutive loader grants, then 1 core grant, then a new lock sequence begins.
- Core write to adr 9 (DEPTH = 8) → mem_w = 0 and memory unchanged; err = 1 on the next cycle only. Core read of adr 9 → rdata = 0, rvalid = 1, err = 1.
- rst asserted in cycle 2 of a locked burst with a read granted → next cycle ldr_rvalid = 0, err = 0; first tie after reset is granted to the core.
